// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths for the 1-to-8 demultiplexer and its 1-to-4 leaves
package demux_pkg;

    // Select width of the full demultiplexer (destination index 0..7).
    localparam int DEMUX_SEL_W  = 3;

    // Number of registered output lines.
    localparam int DEMUX_OUT_W  = 8;

    // Number of output lines handled by one leaf.
    localparam int DEMUX_LEAF_W = 4;

    // Select bits consumed inside a leaf; the remaining MSB steers between leaves.
    localparam int DEMUX_LEAF_SEL_W = DEMUX_SEL_W - 1;

endpackage : demux_pkg

// File: rtl/demux1_4.sv
// rtl/demux1_4.sv - combinational 1-to-4 demultiplexer leaf
module demux1_4
    import demux_pkg::*;
(
    input  logic                        in,
    input  logic [DEMUX_LEAF_SEL_W-1:0] sel,
    output logic [DEMUX_LEAF_W-1:0]     y
);

    // Each output carries the input only when the select matches its index.
    always_comb begin
        y = '0;
        for (int k = 0; k < DEMUX_LEAF_W; k++) begin
            y[k] = in & (sel == DEMUX_LEAF_SEL_W'(k));
        end
    end

endmodule : demux1_4

// File: rtl/demux1_8_using_1_4.sv
// rtl/demux1_8_using_1_4.sv - registered 1-to-8 demultiplexer built from two 1-to-4 leaves
module demux1_8_using_1_4
    import demux_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in,
    input  logic [DEMUX_SEL_W-1:0] sel,
    output logic [DEMUX_OUT_W-1:0] y
);

    logic                    lo_in;
    logic                    hi_in;
    logic [DEMUX_LEAF_W-1:0] lo_y;
    logic [DEMUX_LEAF_W-1:0] hi_y;
    logic [DEMUX_OUT_W-1:0]  y_d;
    logic [DEMUX_OUT_W-1:0]  y_q;

    // Select MSB steers the input to exactly one leaf; the other leaf sees 0.
    always_comb begin
        lo_in = in & ~sel[DEMUX_SEL_W-1];
        hi_in = in &  sel[DEMUX_SEL_W-1];
    end

    demux1_4 u_leaf_lo (
        .in  (lo_in),
        .sel (sel[DEMUX_LEAF_SEL_W-1:0]),
        .y   (lo_y)
    );

    demux1_4 u_leaf_hi (
        .in  (hi_in),
        .sel (sel[DEMUX_LEAF_SEL_W-1:0]),
        .y   (hi_y)
    );

    // High leaf owns lines 7..4, low leaf owns lines 3..0.
    always_comb begin
        y_d = {hi_y, lo_y};
    end

    // Output bank loads every cycle so downstream logic sees clock-aligned lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule : demux1_8_using_1_4

// File: tb/tb_demux1_8_using_1_4.sv
// tb/tb_demux1_8_using_1_4.sv - self-checking bench for the registered 1-to-8 demultiplexer
module tb_demux1_8_using_1_4;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic [2:0] sel;
    logic [7:0] y;

    int vectors;
    int miscompares;

    demux1_8_using_1_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .sel   (sel),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an 8-entry array of destination lines, only line `s` receives `d`.
    function automatic logic [7:0] ref_route(input logic d, input logic [2:0] s);
        logic [7:0] lines;
        int idx;
        idx = int'(s);
        lines = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k == idx) lines[k] = d;
        end
        return lines;
    endfunction

    function automatic int ones(input logic [7:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) n += (v[k] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    task automatic test_reset();
        in = 1'b1;
        sel = 3'd5;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: y=%h expected=%h", y, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (y !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: y=%h expected=%h", i, y, 8'h00);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (y !== 8'h20) begin
            miscompares++;
            $display("FAIL reset_release: y=%h expected=%h", y, 8'h20);
        end
    endtask

    task automatic test_sweep(input logic d);
        logic [7:0] exp_y;
        for (int s = 0; s < 8; s++) begin
            in = d;
            sel = 3'(s);
            exp_y = d ? (8'h01 << s) : 8'h00;
            @(posedge clk);
            #1;
            vectors++;
            if (y !== exp_y) begin
                miscompares++;
                $display("FAIL sweep_in%0d_sel%0d: y=%h expected=%h", d, s, y, exp_y);
            end
        end
    endtask

    task automatic test_leaf_boundary();
        logic [2:0] seq [3];
        logic [7:0] exp_y;
        seq[0] = 3'd3; seq[1] = 3'd4; seq[2] = 3'd3;
        in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = seq[i];
            exp_y = (seq[i] == 3'd3) ? 8'h08 : 8'h10;
            @(posedge clk);
            #1;
            vectors++;
            if (y !== exp_y || (|y[3:0] && |y[7:4])) begin
                miscompares++;
                $display("FAIL leaf_boundary[%0d]: y=%h expected=%h", i, y, exp_y);
            end
        end
    endtask

    task automatic test_mid_reset();
        in = 1'b1;
        sel = 3'd7;
        @(posedge clk);
        #1;
        vectors++;
        if (y !== 8'h80) begin
            miscompares++;
            $display("FAIL midreset_pre: y=%h expected=%h", y, 8'h80);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_async: y=%h expected=%h", y, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (y !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_released_noedge: y=%h expected=%h", y, 8'h00);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (y !== 8'h80) begin
            miscompares++;
            $display("FAIL midreset_recover: y=%h expected=%h", y, 8'h80);
        end
    endtask

    task automatic test_random();
        logic       d_prev;
        logic [2:0] s_prev;
        logic [7:0] exp_y;
        for (int i = 0; i < 200; i++) begin
            in = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            d_prev = in;
            s_prev = sel;
            @(posedge clk);
            #1;
            exp_y = ref_route(d_prev, s_prev);
            vectors++;
            if (y !== exp_y || ones(y) > 1) begin
                miscompares++;
                $display("FAIL random[%0d] in=%0d sel=%0d: y=%h expected=%h", i, d_prev, s_prev, y, exp_y);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        in = 1'b0;
        sel = 3'd0;
        test_reset();
        test_sweep(1'b1);
        test_sweep(1'b0);
        test_leaf_boundary();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_demux1_8_using_1_4
